// File: rtl/posit8_pkg.sv
// Shared constants and types for the 8-bit posit<8,0> datapath.
// FIX_* describe the exact fixed-point form: every posit8 value is a multiple of 2^FIX_LSB_EXP.
package posit8_pkg;

    localparam int POSIT_N     = 8;
    localparam int POSIT_ES    = 0;
    localparam int FIX_W       = 16;
    localparam int FIX_LSB_EXP = -6;
    // Widest fraction field: sign bit plus a two-bit regime leaves the rest.
    localparam int FRAC_W      = POSIT_N - 3 - POSIT_ES;

    localparam logic [POSIT_N-1:0] POSIT_ZERO   = 8'h00;
    localparam logic [POSIT_N-1:0] POSIT_NAR    = 8'h80;
    localparam logic [POSIT_N-1:0] POSIT_MAXPOS = 8'h7F;
    localparam logic [POSIT_N-1:0] POSIT_MINPOS = 8'h01;

    typedef logic [POSIT_N-1:0] posit8_t;

    typedef struct packed {
        logic               is_nar;
        logic               is_zero;
        logic               sign;
        logic signed [3:0]  k;
        logic [FRAC_W-1:0]  frac;
    } posit8_dec_t;

endpackage

// File: rtl/posit8_decode.sv
// Combinational posit<8,0> field decoder: sign, regime scale k and MSB-aligned fraction.
module posit8_decode
    import posit8_pkg::*;
(
    input  posit8_t     p,
    output posit8_dec_t dec
);

    logic [7:0] mag;
    logic [6:0] body;
    logic [6:0] rest;
    logic [3:0] run;
    logic       run_done;

    always_comb begin
        mag      = p[7] ? (~p + 8'd1) : p;
        body     = mag[6:0];
        run      = 4'd0;
        run_done = 1'b0;
        for (int i = 6; i >= 0; i--) begin
            if (!run_done && (body[i] == body[6])) begin
                run = run + 4'd1;
            end else begin
                run_done = 1'b1;
            end
        end
        // Drop the regime run and its terminator; what is left is the fraction, MSB first.
        rest = body << (run + 4'd1);

        dec.is_nar  = (p == POSIT_NAR);
        dec.is_zero = (p == POSIT_ZERO);
        dec.sign    = p[7];
        dec.k       = body[6] ? (run - 4'd1) : (4'd0 - run);
        dec.frac    = rest[6:2];
    end

endmodule

// File: rtl/posit_adder_8bit.sv
// Registered posit<8,0> adder: exact fixed-point add, then normalise, round-to-nearest-even and saturate.
// No handshake: lhs/rhs are sampled on every rising edge and add_result follows one cycle later.
module posit_adder_8bit
    import posit8_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] lhs,
    input  logic [7:0] rhs,
    output logic [7:0] add_result
);

    posit8_dec_t dec_a;
    posit8_dec_t dec_b;

    posit8_decode u_dec_lhs (.p(lhs), .dec(dec_a));
    posit8_decode u_dec_rhs (.p(rhs), .dec(dec_b));

    // Value in units of 2^FIX_LSB_EXP: (1.frac) * 2^k, shifted so k = FIX_LSB_EXP lands on bit 0.
    function automatic logic [FIX_W-1:0] to_fix(input posit8_dec_t d);
        logic [3:0]       shamt;
        logic [17:0]      scaled;
        logic [FIX_W-1:0] mag;
        shamt  = $unsigned(d.k) - 4'(FIX_LSB_EXP);
        scaled = {12'd0, 1'b1, d.frac} << shamt;
        mag    = 16'(scaled >> FRAC_W);
        if (d.is_zero) begin
            mag = '0;
        end
        return d.sign ? (~mag + 16'd1) : mag;
    endfunction

    logic signed [FIX_W-1:0] fix_a;
    logic signed [FIX_W-1:0] fix_b;
    logic signed [FIX_W-1:0] sum;
    logic [FIX_W-1:0]        abs_sum;
    logic                    sum_neg;
    logic [3:0]              lead;
    logic [13:0]             norm;
    logic [4:0]              run;
    logic [31:0]             unbounded;
    logic [6:0]              body;
    logic [6:0]              body_r;
    logic                    guard;
    logic                    sticky;
    logic [7:0]              mag_pat;
    posit8_t                 result_next;

    always_comb begin
        fix_a   = $signed(to_fix(dec_a));
        fix_b   = $signed(to_fix(dec_b));
        sum     = fix_a + fix_b;
        sum_neg = sum[FIX_W-1];
        abs_sum = sum_neg ? (~sum + 16'd1) : sum;

        lead = 4'd0;
        for (int i = 0; i < 14; i++) begin
            if (abs_sum[i]) begin
                lead = 4'(i);
            end
        end
        norm = abs_sum[13:0] << (4'd13 - lead);

        // Scale k = lead - 6: k >= 0 is k+1 ones then 0, k < 0 is -k zeros then 1.
        if (lead >= 4'd6) begin
            run       = 5'(lead) - 5'd5;
            unbounded = ~(32'hFFFF_FFFF >> run) | ({1'b0, norm[12:0], 18'd0} >> run);
        end else begin
            run       = 5'd6 - 5'(lead);
            unbounded = {1'b1, norm[12:0], 18'd0} >> run;
        end

        body   = unbounded[31:25];
        guard  = unbounded[24];
        sticky = |unbounded[23:0];
        body_r = body + 7'(guard & (sticky | body[0]));

        if (abs_sum > 16'd4096) begin
            body_r = POSIT_MAXPOS[6:0];
        end
        if (body_r == 7'd0) begin
            body_r = POSIT_MINPOS[6:0];
        end
        mag_pat = {1'b0, body_r};

        if (dec_a.is_nar || dec_b.is_nar) begin
            result_next = POSIT_NAR;
        end else if (dec_a.is_zero) begin
            result_next = rhs;
        end else if (dec_b.is_zero) begin
            result_next = lhs;
        end else if (sum == '0) begin
            result_next = POSIT_ZERO;
        end else begin
            result_next = sum_neg ? (~mag_pat + 8'd1) : mag_pat;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            add_result <= POSIT_ZERO;
        end else begin
            add_result <= result_next;
        end
    end

endmodule

// File: tb/tb_posit_adder_8bit.sv
// Bench for posit_adder_8bit: directed cases, reset behaviour, exhaustive sweep and random back-to-back stream.
module tb_posit_adder_8bit;

    logic       clk;
    logic       rst_n;
    logic [7:0] lhs;
    logic [7:0] rhs;
    logic [7:0] add_result;

    int         checks;
    int         errors;
    logic [7:0] exp_q[$];
    logic [7:0] exp_v;
    real        pos_val[128];
    logic [7:0] dir_a[10];
    logic [7:0] dir_b[10];
    logic [7:0] dir_e[10];

    posit_adder_8bit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .lhs        (lhs),
        .rhs        (rhs),
        .add_result (add_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Real value of a posit<8,0> pattern (NaR is never passed in).
    function automatic real pval(input logic [7:0] p);
        logic [7:0] m;
        logic       r;
        int         run;
        int         i;
        int         k;
        real        f;
        real        w;
        real        scale;
        if (p == 8'h00) return 0.0;
        m   = p[7] ? (8'h00 - p) : p;
        r   = m[6];
        run = 0;
        i   = 6;
        while (i >= 0 && m[i] == r) begin
            run++;
            i--;
        end
        k = r ? run - 1 : -run;
        i--;
        f = 0.0;
        w = 0.5;
        while (i >= 0) begin
            if (m[i]) f = f + w;
            w = w / 2.0;
            i--;
        end
        scale = 1.0;
        if (k >= 0) repeat (k) scale = scale * 2.0;
        else repeat (-k) scale = scale / 2.0;
        return p[7] ? -(1.0 + f) * scale : (1.0 + f) * scale;
    endfunction

    // Nearest representable posit to the exact real sum, ties to the even pattern, saturating.
    function automatic logic [7:0] model_add(input logic [7:0] a, input logic [7:0] b);
        real s;
        real mag;
        real d;
        real bd;
        int  best;
        if (a == 8'h80 || b == 8'h80) return 8'h80;
        s = pval(a) + pval(b);
        if (s == 0.0) return 8'h00;
        mag = (s < 0.0) ? -s : s;
        if (mag >= pos_val[127]) begin
            best = 127;
        end else begin
            best = 1;
            bd   = (mag > pos_val[1]) ? mag - pos_val[1] : pos_val[1] - mag;
            for (int j = 2; j < 128; j++) begin
                d = (mag > pos_val[j]) ? mag - pos_val[j] : pos_val[j] - mag;
                if (d < bd || (d == bd && j[0] == 1'b0)) begin
                    best = j;
                    bd   = d;
                end
            end
        end
        return (s < 0.0) ? 8'(256 - best) : 8'(best);
    endfunction

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [7:0] e);
        @(negedge clk);
        lhs = a;
        rhs = b;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        lhs   = 8'h40;
        rhs   = 8'h40;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (add_result !== 8'h00) begin
            errors++;
            $display("FAIL reset_state: got %h expected 00", add_result);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        dir_a = '{8'h02, 8'h40, 8'h40, 8'h40, 8'h00, 8'h7F, 8'h81, 8'h80, 8'h00, 8'h5A};
        dir_b = '{8'hFF, 8'h40, 8'h20, 8'hC0, 8'h5A, 8'h7F, 8'h81, 8'h40, 8'h80, 8'h00};
        dir_e = '{8'h01, 8'h60, 8'h50, 8'h00, 8'h5A, 8'h7F, 8'h81, 8'h80, 8'h80, 8'h5A};
        for (int i = 0; i < 10; i++) begin
            drive(dir_a[i], dir_b[i], dir_e[i]);
            @(posedge clk);
            #1;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL directed_%0d: scoreboard empty", i);
            end else begin
                exp_v = exp_q.pop_front();
                if (add_result !== exp_v) begin
                    errors++;
                    $display("FAIL directed_%0d: %h+%h got %h expected %h",
                             i, dir_a[i], dir_b[i], add_result, exp_v);
                end
            end
        end
    endtask

    task automatic test_reset_midstream();
        drive(8'h40, 8'h40, 8'h60);
        @(posedge clk);
        #1;
        checks++;
        exp_v = exp_q.pop_front();
        if (add_result !== exp_v) begin
            errors++;
            $display("FAIL pre_reset: got %h expected %h", add_result, exp_v);
        end
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (add_result !== 8'h00) begin
                errors++;
                $display("FAIL midstream_reset_%0d: got %h expected 00", i, add_result);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_sweep();
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 256; b++) begin
                drive(8'(a), 8'(b), model_add(8'(a), 8'(b)));
                @(posedge clk);
                #1;
                checks++;
                exp_v = exp_q.pop_front();
                if (add_result !== exp_v) begin
                    errors++;
                    $display("FAIL sweep: %h+%h got %h expected %h", 8'(a), 8'(b), add_result, exp_v);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] a;
        logic [7:0] b;
        for (int i = 0; i < 300; i++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            // Odd steps feed the swapped pair so commutativity is exercised back to back.
            if (i[0]) drive(b, a, model_add(a, b));
            else drive(a, b, model_add(a, b));
            @(posedge clk);
            #1;
            checks++;
            exp_v = exp_q.pop_front();
            if (add_result !== exp_v) begin
                errors++;
                $display("FAIL back_to_back_%0d: %h/%h got %h expected %h", i, a, b, add_result, exp_v);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        lhs    = 8'h00;
        rhs    = 8'h00;
        rst_n  = 1'b0;
        for (int j = 0; j < 128; j++) pos_val[j] = pval(8'(j));

        test_reset();
        test_directed();
        test_reset_midstream();
        test_sweep();
        test_back_to_back();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
